fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage feeding the controller/datapath. Owns the fetch PC, issues
//   word reads to instruction memory over a req/ack handshake, and buffers one fetched
//   instruction (Instr, PC, PCPlus8) until the core consumes it. Applies PCSrc/branch
//   redirects from condition logic when the buffered instruction retires.
// PARAMETERS
//   RESET_PC   32'h0000_0000   address of first fetch after reset (word aligned)
// PORTS
//   clk            in   1   clock, all state updates on rising edge
//   reset          in   1   asynchronous, active-high reset
//   imem_req       out  1   read request to instruction memory
//   imem_addr      out  32  read address, word aligned, stable while imem_req=1
//   imem_ack       in   1   read complete; imem_rdata valid in same cycle
//   imem_rdata     in   32  instruction word returned by memory
//   stall          in   1   core cannot consume this cycle
//   PCSrc          in   1   retiring instruction redirects PC (sampled on consume only)
//   branch_target  in   32  redirect address (sampled on consume with PCSrc=1)
//   Instr          out  32  buffered instruction to decoder
//   instr_valid    out  1   Instr/PC/PCPlus8 hold a valid instruction
//   PC             out  32  address of Instr
//   PCPlus8        out  32  PC + 8 (architectural R15 read value)
// BEHAVIOUR
//   - Reset (async): state=BOOT, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//     instr_valid=0, Instr=0, PC=RESET_PC, PCPlus8=RESET_PC+8.
//   - consume = instr_valid & ~stall.
//   - FSM: BOOT -> REQ unconditionally after first clock following reset release.
//     REQ: imem_req=1, imem_addr=fetch_pc. On imem_ack: Instr<=imem_rdata,
//       PC<=fetch_pc, PCPlus8<=fetch_pc+8, fetch_pc<=fetch_pc+4, instr_valid<=1 -> FULL.
//       No ack: hold; imem_addr must not change.
//     FULL: imem_req=0. On consume: instr_valid<=0 -> REQ; if PCSrc=1,
//       fetch_pc<=branch_target & ~32'h3 (low bits forced to 0), else fetch_pc unchanged
//       (already PC+4). No consume: hold all outputs.
//   - imem_req and imem_addr driven from registered state only (no comb. path from inputs).
//   - Latency: zero-wait memory (ack in first REQ cycle) -> instr_valid one cycle later;
//     N wait cycles add N. Max throughput: one instruction per 2 cycles.
//   - imem_ack while not in REQ/BOOT/FULL-without-request: ignored, no state change.
//   - stall, PCSrc, branch_target ignored when instr_valid=0.
//   - Arithmetic mod 2^32: fetch_pc 32'hFFFF_FFFC + 4 wraps to 0; PCPlus8 wraps likewise.
//   - Reset asserted mid-REQ: request dropped immediately (imem_req=0 asynchronously),
//     in-flight ack in later cycles ignored until REQ re-entered; fetch restarts at RESET_PC.
// TESTING
//   1. Reset, release, ack every REQ with 0 wait -> req at 0,4,8 every 2nd cycle;
//      PC/PCPlus8 = 0/8, 4/12, 8/16.
//   2. Ack delayed 3 cycles -> imem_req high 4 cycles, imem_addr stable 0x0;
//      instr_valid rises cycle after ack, Instr = returned word.
//   3. Hold stall=1 for 5 cycles in FULL -> Instr/PC unchanged, imem_req=0; drop stall
//      -> next request at PC+4.
//   4. Consume with PCSrc=1, branch_target=0x0000_0103 -> next imem_addr=0x0000_0100.
//   5. Assert reset during REQ at addr 0x40 with ack pending -> imem_req=0 same cycle;
//      after release first fetch at RESET_PC; stale ack before REQ ignored.
//   6. Redirect to 0xFFFF_FFFC, consume -> next fetch addr 0x0000_0000; PCPlus8 of
//      first instr = 0x0000_0004.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
// The fetch stage is the master; memory (or a bench model) is the slave.
interface fetch_unit_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, reads instruction memory over req/ack and holds
// one instruction (Instr, PC, PCPlus8) until the core consumes it.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   fetch_unit_if.master        imem,
   input  logic                stall,
   input  logic                PCSrc,
   input  logic [31:0]         branch_target,
   output logic [31:0]         Instr,
   output logic                instr_valid,
   output logic [31:0]         PC,
   output logic [31:0]         PCPlus8
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {BOOT, REQ, FULL} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   instr_d, pc_d, pc8_d;
   logic              valid_d;
   logic              req_q, req_d;
   logic              consume_c;

   assign consume_c      = instr_valid & ~stall;
   // Request and address come straight from flops; fetch_pc only moves outside REQ.
   assign imem.imem_req  = req_q;
   assign imem.imem_addr = fetch_pc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= BOOT;
         fetch_pc_q  <= RESET_PC;
         req_q       <= 1'b0;
         Instr       <= '0;
         instr_valid <= 1'b0;
         PC          <= RESET_PC;
         PCPlus8     <= RESET_PC + XLEN'(8);
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_q       <= req_d;
         Instr       <= instr_d;
         instr_valid <= valid_d;
         PC          <= pc_d;
         PCPlus8     <= pc8_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = Instr;
      pc_d       = PC;
      pc8_d      = PCPlus8;
      valid_d    = instr_valid;
      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (imem.imem_ack) begin
               instr_d    = imem.imem_rdata;
               pc_d       = fetch_pc_q;
               pc8_d      = fetch_pc_q + XLEN'(8);
               fetch_pc_d = fetch_pc_q + XLEN'(4);
               valid_d    = 1'b1;
               state_d    = FULL;
            end
         end
         FULL: begin
            // fetch_pc already holds PC+4; only a taken redirect overrides it
            if (consume_c) begin
               valid_d = 1'b0;
               state_d = REQ;
               if (PCSrc) fetch_pc_d = branch_target & ~XLEN'(3);
            end
         end
         default: state_d = BOOT;
      endcase
      req_d = (state_d == REQ);
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory responder + consumer with a PC-sequence
// model, scoreboard of expected instructions popped on every consume.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        PCSrc;
   logic [31:0] branch_target;
   logic [31:0] Instr;
   logic        instr_valid;
   logic [31:0] PC;
   logic [31:0] PCPlus8;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem         (bus),
      .stall        (stall),
      .PCSrc        (PCSrc),
      .branch_target(branch_target),
      .Instr        (Instr),
      .instr_valid  (instr_valid),
      .PC           (PC),
      .PCPlus8      (PCPlus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    errors = 0;
   int    checks = 0;
   int    n_consumed = 0;
   exp_t  exp_q[$];

   logic [31:0] model_pc;
   int          wait_left;
   bit          ack_prev;
   int          cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(0, 4))
         0: t = 32'h0000_0103;
         1: t = 32'hFFFF_FFFC;
         2: t = 32'hFFFF_FFFF;
         default: t = $urandom;
      endcase
      return t;
   endfunction

   // One cycle: observe at posedge+1, drive the memory and consumer, advance a clock.
   task automatic step(input bit allow_ack);
      if (ack_prev) chk("valid_after_ack", 32'(instr_valid), 32'd1);
      if (instr_valid) chk("req_low_while_full", 32'(bus.imem_req), 32'd0);
      if (bus.imem_req) chk("req_addr", bus.imem_addr, model_pc);

      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      if (bus.imem_req) begin
         if (wait_left < 0) wait_left = $urandom_range(0, 3);
         if (allow_ack && wait_left == 0) begin
            bus.imem_ack = 1'b1;
            exp_q.push_back('{instr: bus.imem_rdata, pc: model_pc, pc8: model_pc + 32'd8});
            model_pc  = model_pc + 32'd4;
            wait_left = -1;
         end else if (wait_left > 0) begin
            wait_left--;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         bus.imem_ack = 1'b1;   // stale ack outside REQ must be ignored
      end
      ack_prev = bus.imem_ack && bus.imem_req;

      // periodic 5-cycle stall bursts on top of random stalls
      stall         = ((cyc % 40) < 5) || ($urandom_range(0, 3) == 0);
      PCSrc         = ($urandom_range(0, 2) == 0);
      branch_target = pick_target();
      if (instr_valid && !stall && PCSrc) model_pc = branch_target & ~32'h3;

      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compare whenever the core consumes an instruction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && instr_valid && !stall) begin
            n_consumed++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL consume_unexpected: got PC %h expected no instruction", PC);
            end else begin
               e = exp_q.pop_front();
               chk("instr", Instr, e.instr);
               chk("pc", PC, e.pc);
               chk("pcplus8", PCPlus8, e.pc8);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b1; PCSrc = 1'b0; branch_target = '0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      wait_left = -1; ack_prev = 1'b0; cyc = 0; model_pc = RESET_PC;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", bus.imem_addr, RESET_PC);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", Instr, 32'd0);
      chk("rst_pc", PC, RESET_PC);
      chk("rst_pc8", PCPlus8, RESET_PC + 32'd8);

      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("boot_to_req", 32'(bus.imem_req), 32'd1);
      chk("boot_addr", bus.imem_addr, RESET_PC);

      repeat (800) step(1'b1);

      // Reach a fresh REQ cycle without acking, then reset with an ack pending.
      for (int i = 0; i < 50 && !(bus.imem_req && !instr_valid); i++) step(1'b0);
      chk("req_before_reset", 32'(bus.imem_req), 32'd1);
      bus.imem_ack = 1'b1;
      reset = 1'b1;
      #1;
      chk("reset_drops_req", 32'(bus.imem_req), 32'd0);
      chk("reset_clears_valid", 32'(instr_valid), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_addr", bus.imem_addr, RESET_PC);
      reset = 1'b0;
      @(posedge clk);   // BOOT edge: the still-high ack must be ignored
      #1;
      chk("restart_req", 32'(bus.imem_req), 32'd1);
      chk("restart_addr", bus.imem_addr, RESET_PC);
      chk("stale_ack_ignored", 32'(instr_valid), 32'd0);
      bus.imem_ack = 1'b0;
      model_pc = RESET_PC; wait_left = -1; ack_prev = 1'b0;

      repeat (800) step(1'b1);

      chk("throughput", 32'(n_consumed >= 100), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
